// File: rtl/uart_alu_pkg.sv
// rtl/uart_alu_pkg.sv - shared opcodes, header constants and framer state type for the UART ALU link
package uart_alu_pkg;

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hAD;
    localparam logic [7:0] OP_MUL  = 8'h88;
    localparam logic [7:0] OP_DIV  = 8'hD0;

    // Header is opcode, reserved byte, len[7:0], len[15:8]
    localparam int         HDR_BYTES    = 4;
    localparam logic [7:0] HDR_RESERVED = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAY
    } framer_state_e;

endpackage

// File: rtl/uart_alu_op_fifo.sv
// rtl/uart_alu_op_fifo.sv - synchronous operand FIFO with wrap-bit pointers
//
// Ports:
//   clk_i, rst_ni   clock, async active-low reset (flushes pointers)
//   push_i, wdata_i write one word; caller guarantees !full_o or a same-cycle pop_i
//   pop_i           discard head word; caller guarantees !empty_o
//   rdata_o         head word (valid while !empty_o)
//   full_o, empty_o occupancy flags
module uart_alu_op_fifo
    import uart_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    // Storage needs no reset; pointers alone define validity.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign rdata_o = mem[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    // Same index, opposite lap: writer is a full buffer ahead of the reader.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/uart_alu_pkt_framer.sv
// rtl/uart_alu_pkt_framer.sv - frames opcode + buffered operands into a UART ALU byte packet
//
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   cmd_valid_i/cmd_ready_o            command handshake (ready only in IDLE)
//   cmd_opcode_i, cmd_count_i          packet opcode and operand count
//   op_valid_i/op_ready_o, op_data_i   operand push into the FIFO
//   m_axis_tdata_o/tvalid_o/tready_i   byte stream towards uart_tx
//   busy_o                             packet in progress
//   pkt_done_o                         pulse on last-byte handshake
//   err_o                              pulse after an illegal command was dropped
module uart_alu_pkt_framer
    import uart_alu_pkg::*;
#(
    parameter int OPERAND_WIDTH = 32,
    parameter int MAX_OPERANDS  = 16,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [7:0]               cmd_opcode_i,
    input  logic [7:0]               cmd_count_i,
    input  logic                     op_valid_i,
    output logic                     op_ready_o,
    input  logic [OPERAND_WIDTH-1:0] op_data_i,
    output logic [7:0]               m_axis_tdata_o,
    output logic                     m_axis_tvalid_o,
    input  logic                     m_axis_tready_i,
    output logic                     busy_o,
    output logic                     pkt_done_o,
    output logic                     err_o
);

    localparam int BYTES = OPERAND_WIDTH / 8;
    localparam int JW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    if ((OPERAND_WIDTH % 8 != 0) || (HDR_BYTES + MAX_OPERANDS * BYTES > 65535)) begin : g_param_check
        $error("uart_alu_pkt_framer: illegal OPERAND_WIDTH/MAX_OPERANDS combination");
    end

    localparam logic [JW-1:0] LAST_J     = JW'(BYTES - 1);
    localparam logic [JW-1:0] J_AFTERPOP = JW'((BYTES == 1) ? 0 : 1);

    framer_state_e            state_q;
    logic [2:0]               hdr_idx_q;   // next header byte to load
    logic [JW-1:0]            byte_idx_q;  // next operand byte to load; 0 = needs a new operand
    logic [7:0]               ops_left_q;  // operands not yet popped for this packet
    logic [15:0]              len_q;
    logic [OPERAND_WIDTH-1:0] sreg_q;      // remaining bytes of the current operand
    logic                     last_q;      // output register holds the packet's final byte
    logic [7:0]               tdata_q;
    logic                     tvalid_q;
    logic                     err_q;

    logic [OPERAND_WIDTH-1:0] fifo_rdata;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     push;
    logic                     pop;
    logic                     load_slot;
    logic                     want_op;
    logic                     illegal;
    logic [15:0]              len_calc;

    // The output register may take a new byte when it is empty or being drained this edge.
    assign load_slot = !tvalid_q || m_axis_tready_i;

    // A new operand is needed after the last header byte and at every operand boundary.
    assign want_op = load_slot &&
                     (((state_q == HDR) && (hdr_idx_q == 3'(HDR_BYTES))) ||
                      ((state_q == PAY) && (byte_idx_q == '0) && (ops_left_q != 8'd0)));
    assign pop     = want_op && !fifo_empty;

    // A pop frees a slot this edge, so a full FIFO can still take a word.
    assign op_ready_o = !fifo_full || pop;
    assign push       = op_valid_i && op_ready_o;

    assign illegal  = (cmd_count_i == 8'd0) || (cmd_count_i > 8'(MAX_OPERANDS));
    assign len_calc = 16'(HDR_BYTES) + 16'(cmd_count_i) * 16'(BYTES);

    uart_alu_op_fifo #(
        .WIDTH (OPERAND_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_op_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .wdata_i (op_data_i),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            hdr_idx_q  <= '0;
            byte_idx_q <= '0;
            ops_left_q <= '0;
            len_q      <= '0;
            sreg_q     <= '0;
            last_q     <= 1'b0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        if (illegal) begin
                            err_q <= 1'b1;
                        end else begin
                            len_q      <= len_calc;
                            ops_left_q <= cmd_count_i;
                            tdata_q    <= cmd_opcode_i;
                            tvalid_q   <= 1'b1;
                            hdr_idx_q  <= 3'd1;
                            byte_idx_q <= '0;
                            last_q     <= 1'b0;
                            state_q    <= HDR;
                        end
                    end
                end
                HDR: begin
                    if (m_axis_tready_i) begin
                        if (hdr_idx_q == 3'(HDR_BYTES)) begin
                            state_q <= PAY;  // first operand byte is loaded by the pop path below
                        end else begin
                            hdr_idx_q <= hdr_idx_q + 3'd1;
                            case (hdr_idx_q)
                                3'd1:    tdata_q <= HDR_RESERVED;
                                3'd2:    tdata_q <= len_q[7:0];
                                default: tdata_q <= len_q[15:8];
                            endcase
                        end
                    end
                end
                PAY: begin
                    if (last_q) begin
                        if (m_axis_tready_i) begin
                            tvalid_q <= 1'b0;
                            last_q   <= 1'b0;
                            state_q  <= IDLE;
                        end
                    end else if (load_slot && (byte_idx_q != '0)) begin
                        tdata_q    <= sreg_q[7:0];
                        sreg_q     <= sreg_q >> 8;
                        tvalid_q   <= 1'b1;
                        last_q     <= (byte_idx_q == LAST_J) && (ops_left_q == 8'd0);
                        byte_idx_q <= (byte_idx_q == LAST_J) ? '0 : byte_idx_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Operand fetch shared by HDR->PAY and PAY boundaries; an empty FIFO idles the stream.
            if (pop) begin
                tdata_q    <= fifo_rdata[7:0];
                sreg_q     <= fifo_rdata >> 8;
                tvalid_q   <= 1'b1;
                ops_left_q <= ops_left_q - 8'd1;
                byte_idx_q <= J_AFTERPOP;
                last_q     <= (BYTES == 1) && (ops_left_q == 8'd1);
            end else if (want_op) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    assign cmd_ready_o     = (state_q == IDLE);
    assign busy_o          = (state_q != IDLE);
    assign m_axis_tdata_o  = tdata_q;
    assign m_axis_tvalid_o = tvalid_q;
    assign pkt_done_o      = tvalid_q && m_axis_tready_i && last_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_uart_alu_pkt_framer.sv
// tb/tb_uart_alu_pkt_framer.sv - self-checking bench for uart_alu_pkt_framer
module tb_uart_alu_pkt_framer;
    import uart_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode = 8'h00;
    logic [7:0]  cmd_count = 8'h00;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [31:0] op_data = 32'h0;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready = 1'b0;
    logic        busy;
    logic        pkt_done;
    logic        err;

    always #5 clk = ~clk;

    uart_alu_pkt_framer #(
        .OPERAND_WIDTH (32),
        .MAX_OPERANDS  (16),
        .FIFO_DEPTH    (16)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .cmd_valid_i     (cmd_valid),
        .cmd_ready_o     (cmd_ready),
        .cmd_opcode_i    (cmd_opcode),
        .cmd_count_i     (cmd_count),
        .op_valid_i      (op_valid),
        .op_ready_o      (op_ready),
        .op_data_i       (op_data),
        .m_axis_tdata_o  (tdata),
        .m_axis_tvalid_o (tvalid),
        .m_axis_tready_i (tready),
        .busy_o          (busy),
        .pkt_done_o      (pkt_done),
        .err_o           (err)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int stall_pct = 0;

    // Observation / reference model state
    logic [7:0]  got_q[$];
    int          got_cyc[$];
    int          done_cyc[$];
    logic [31:0] op_q[$];
    logic [7:0]  cmd_op_q[$];
    int          cmd_cnt_q[$];
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          exp_err = 0;
    int          err_cyc = -1;
    int          cmd_cyc = -1;
    int          op_cyc = -1;
    logic        hold_pend = 1'b0;
    logic [7:0]  hold_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        #1;
        tready = ($urandom_range(0, 99) >= stall_pct);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_pend) begin
                chk("hold_stable", {23'd0, tvalid, tdata}, {23'd0, 1'b1, hold_data});
            end
            hold_pend = tvalid && !tready;
            hold_data = tdata;
            if (tvalid && tready) begin
                got_q.push_back(tdata);
                got_cyc.push_back(cyc);
            end
            if (pkt_done) begin
                done_cnt++;
                done_cyc.push_back(cyc);
                chk("done_on_handshake", 32'(tvalid && tready), 32'd1);
            end
            if (err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (op_valid && op_ready) begin
                op_q.push_back(op_data);
                op_cyc = cyc;
            end
            if (cmd_valid && cmd_ready) begin
                cmd_cyc = cyc;
                if (cmd_count == 8'd0 || cmd_count > 8'd16) begin
                    exp_err++;
                end else begin
                    cmd_op_q.push_back(cmd_opcode);
                    cmd_cnt_q.push_back(int'(cmd_count));
                end
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    task automatic push_op(input logic [31:0] v);
        int n = 0;
        op_valid = 1'b1;
        op_data  = v;
        @(negedge clk);
        while (!op_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("push_timeout", 32'(op_ready), 32'd1);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] opc, input logic [7:0] cnt);
        int n = 0;
        cmd_valid  = 1'b1;
        cmd_opcode = opc;
        cmd_count  = cnt;
        @(negedge clk);
        while (!cmd_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("cmd_timeout", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt < target) chk("done_timeout", 32'(done_cnt), 32'(target));
        #1;
    endtask

    // Reference: each legal command yields opcode, 0, len LE, then its operands LE,
    // operands taken from the pushed stream in order.
    task automatic check_stream();
        logic [7:0]  exp_b[$];
        logic [31:0] v;
        int          cnt;
        int          len;
        while (cmd_op_q.size() > 0) begin
            cnt = cmd_cnt_q.pop_front();
            len = 4 + cnt * 4;
            exp_b.push_back(cmd_op_q.pop_front());
            exp_b.push_back(8'h00);
            exp_b.push_back(8'(len % 256));
            exp_b.push_back(8'(len / 256));
            for (int k = 0; k < cnt; k++) begin
                if (op_q.size() == 0) begin
                    chk("model_operand_missing", 32'd0, 32'd1);
                    v = 32'h0;
                end else begin
                    v = op_q.pop_front();
                end
                for (int b = 0; b < 4; b++) exp_b.push_back(8'(v >> (8 * b)));
            end
        end
        chk("byte_count", 32'(got_q.size()), 32'(exp_b.size()));
        for (int i = 0; i < got_q.size() && i < exp_b.size(); i++) begin
            chk($sformatf("byte[%0d]", i), 32'(got_q[i]), 32'(exp_b[i]));
        end
        got_q.delete();
        got_cyc.delete();
    endtask

    typedef struct {
        logic [7:0]  opcode;
        int          count;
        int          stall;
        int          pre;
        logic [15:0] exp_len;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0] echo_exp[8];
        logic [7:0] add_exp[12];
        int tgt;
        int c0;
        int e0;
        int n;

        vecs[0] = '{OP_ADD,  3,  0,  3, 16'd16};
        vecs[1] = '{OP_MUL, 16, 25, 16, 16'd68};
        vecs[2] = '{OP_DIV,  5, 50,  2, 16'd24};
        vecs[3] = '{OP_ECHO, 1, 80,  0, 16'd8};
        vecs[4] = '{8'h5A,   7, 10,  4, 16'd32};
        vecs[5] = '{OP_MUL,  2,  0,  0, 16'd12};
        echo_exp = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        add_exp  = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                     8'h02, 8'h00, 8'h00, 8'h00};

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_op_ready",  32'(op_ready),  32'd1);
        chk("rst_tvalid",    32'(tvalid),    32'd0);
        chk("rst_tdata",     32'(tdata),     32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_pkt_done",  32'(pkt_done),  32'd0);
        chk("rst_err",       32'(err),       32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Echo at full throughput with exact timing
        stall_pct = 0;
        push_op(32'hDEADBEEF);
        tgt = done_cnt + 1;
        send_cmd(OP_ECHO, 8'd1);
        c0 = cmd_cyc;
        wait_done(tgt);
        chk("echo_len", 32'(got_q.size()), 32'd8);
        if (got_q.size() >= 8) begin
            for (int i = 0; i < 8; i++) chk("echo_byte", 32'(got_q[i]), 32'(echo_exp[i]));
            chk("echo_first_cyc", 32'(got_cyc[0]), 32'(c0 + 1));
            chk("echo_last_cyc",  32'(got_cyc[7]), 32'(c0 + 8));
            chk("echo_done_cyc",  32'(done_cyc[done_cyc.size() - 1]), 32'(c0 + 8));
        end
        check_stream();

        // Add 1,2 under random backpressure
        stall_pct = 40;
        push_op(32'd1);
        push_op(32'd2);
        tgt = done_cnt + 1;
        send_cmd(OP_ADD, 8'd2);
        wait_done(tgt);
        chk("add_len", 32'(got_q.size()), 32'd12);
        for (int i = 0; i < 12 && i < got_q.size(); i++) chk("add_byte", 32'(got_q[i]), 32'(add_exp[i]));
        check_stream();

        // Table-driven random packets
        for (int v = 0; v < 6; v++) begin
            stall_pct = vecs[v].stall;
            for (int k = 0; k < vecs[v].pre; k++) push_op($urandom);
            tgt = done_cnt + 1;
            send_cmd(vecs[v].opcode, 8'(vecs[v].count));
            for (int k = vecs[v].pre; k < vecs[v].count; k++) push_op($urandom);
            wait_done(tgt);
            if (got_q.size() >= 4) chk("tbl_len_field", {16'd0, got_q[3], got_q[2]}, {16'd0, vecs[v].exp_len});
            else chk("tbl_short", 32'(got_q.size()), 32'd4);
            check_stream();
        end

        // Operand starvation at a boundary
        stall_pct = 0;
        push_op(32'h11223344);
        tgt = done_cnt + 1;
        send_cmd(OP_ADD, 8'd2);
        c0 = cmd_cyc;
        repeat (20) @(posedge clk);
        #1;
        push_op(32'hA5A55A5A);
        wait_done(tgt);
        if (got_cyc.size() >= 12) begin
            chk("starve_byte8_cyc", 32'(got_cyc[7]), 32'(c0 + 8));
            chk("starve_resume_cyc", 32'(got_cyc[8]), 32'(op_cyc + 2));
            chk("starve_tail_cyc", 32'(got_cyc[11]), 32'(got_cyc[8] + 3));
        end
        check_stream();

        // Illegal counts
        foreach (echo_exp[i]) begin
            if (i < 2) begin
                e0 = err_cnt;
                send_cmd(OP_ADD, (i == 0) ? 8'd0 : 8'd17);
                repeat (3) @(posedge clk);
                #1;
                chk("illegal_err_count", 32'(err_cnt), 32'(e0 + 1));
                chk("illegal_err_cyc", 32'(err_cyc), 32'(cmd_cyc + 1));
                chk("illegal_no_bytes", 32'(got_q.size()), 32'd0);
                chk("illegal_cmd_ready", 32'(cmd_ready), 32'd1);
                chk("illegal_busy", 32'(busy), 32'd0);
            end
        end

        // Full FIFO, then push+pop in the same cycle
        stall_pct = 0;
        for (int k = 0; k < 16; k++) push_op($urandom);
        @(negedge clk);
        chk("full_op_ready", 32'(op_ready), 32'd0);
        @(posedge clk);
        #1;
        tgt = done_cnt + 1;
        send_cmd(OP_MUL, 8'd16);
        push_op(32'hCAFEF00D);
        @(negedge clk);
        chk("still_full_op_ready", 32'(op_ready), 32'd0);
        wait_done(tgt);
        check_stream();
        tgt = done_cnt + 1;
        send_cmd(OP_ECHO, 8'd1);
        wait_done(tgt);
        check_stream();

        // Back-to-back echo packets
        push_op($urandom);
        push_op($urandom);
        tgt = done_cnt + 1;
        send_cmd(OP_ECHO, 8'd1);
        send_cmd(OP_ECHO, 8'd1);
        wait_done(tgt + 1);
        if (got_cyc.size() >= 16 && done_cyc.size() >= 2) begin
            chk("b2b_second_hdr_cyc", 32'(got_cyc[8]), 32'(done_cyc[done_cyc.size() - 2] + 2));
            chk("b2b_second_tail_cyc", 32'(got_cyc[15]), 32'(got_cyc[8] + 7));
        end
        check_stream();

        // Reset in the middle of the payload; the leftover operand must be flushed
        push_op(32'h01020304);
        push_op(32'h0BADF00D);
        send_cmd(OP_ECHO, 8'd1);
        n = 0;
        while (got_q.size() < 5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reached_payload", 32'(got_q.size() >= 5), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tvalid",    32'(tvalid),    32'd0);
        chk("mid_rst_tdata",     32'(tdata),     32'd0);
        chk("mid_rst_busy",      32'(busy),      32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_op_ready",  32'(op_ready),  32'd1);
        chk("mid_rst_pkt_done",  32'(pkt_done),  32'd0);
        chk("mid_rst_err",       32'(err),       32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        got_q.delete();
        got_cyc.delete();
        op_q.delete();
        cmd_op_q.delete();
        cmd_cnt_q.delete();
        push_op(32'h76543210);
        tgt = done_cnt + 1;
        send_cmd(OP_ECHO, 8'd1);
        wait_done(tgt);
        check_stream();

        repeat (3) @(posedge clk);
        #1;
        chk("err_total", 32'(err_cnt), 32'(exp_err));
        chk("no_stray_bytes", 32'(got_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
